// File: rtl/tlp_pkg.sv
// Shared constants and types for the TLP write-request sink.
package tlp_pkg;

   localparam logic [6:0] FMT_MWR32 = 7'h40;
   localparam logic [6:0] FMT_MWR64 = 7'h60;

   // tuser bit positions carried alongside every rebuilt video beat
   localparam int TU_SOF = 0;
   localparam int TU_SOL = 1;
   localparam int TU_EOL = 2;
   localparam int TU_EOF = 3;

   // sticky error flag positions
   localparam int ERR_FMT   = 0;
   localparam int ERR_ALIGN = 1;
   localparam int ERR_ADDR  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DATA,
      ST_DROP
   } sink_state_e;

   function automatic logic fmt_supported(input logic [6:0] fmt);
      return (fmt == FMT_MWR32) || (fmt == FMT_MWR64);
   endfunction

endpackage

// File: rtl/tlp2axis_fifo.sv
// Synchronous FIFO holding {tuser, tdata} beats; reports free entries so the
// sink can reserve headroom for a whole TLP before granting it.
module tlp2axis_fifo #(
   parameter  int WIDTH = 68,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic [AW:0]      free_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign valid_o    = (count_q != '0);
   assign free_o     = (AW+1)'(DEPTH) - count_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && valid_o;

   // storage array, written on every accepted push
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/tlp2axis_sink.sv
// Consumer of memory-write TLPs: grants requests, checks each TLP address
// against the running frame-buffer position and rebuilds the video stream.
//
// state | meaning
// IDLE  | waiting for a request with enough FIFO headroom for a max-size TLP
// GRANT | one-cycle grant; header fields are evaluated and latched
// DATA  | accepting payload beats into the FIFO, advancing line/frame counters
// DROP  | consuming payload of a rejected TLP without touching counters
module tlp2axis_sink
   import tlp_pkg::*;
#(
   parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
   parameter int FIFO_DEPTH            = 64
) (
   input  logic        axi_clk,
   input  logic        axi_reset,
   input  logic [63:0] cfg_fstart,
   input  logic [23:0] cfg_line_size,
   input  logic [31:0] cfg_line_pitch,
   input  logic [15:0] cfg_line_count,
   input  logic        tlp_req_to_send,
   output logic        tlp_grant,
   input  logic [6:0]  tlp_fmt_type,
   input  logic [9:0]  tlp_length_in_dw,
   input  logic [63:0] tlp_address,
   input  logic        tlp_src_rdy_n,
   output logic        tlp_dst_rdy_n,
   input  logic [63:0] tlp_data,
   input  logic [7:0]  tlp_ldwbe_fdwbe,
   input  logic [1:0]  tlp_attr,
   input  logic [23:0] tlp_transaction_id,
   input  logic [12:0] tlp_byte_count,
   input  logic [6:0]  tlp_lower_address,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [3:0]  m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        frame_done,
   output logic [2:0]  err_flags
);

   localparam int HEADROOM = MAX_PCIE_PAYLOAD_SIZE / 8;
   localparam int FAW      = $clog2(FIFO_DEPTH);

   sink_state_e state_q;
   logic        grant_q;
   logic        dst_rdy_n_q;
   logic        frame_done_q;
   logic [2:0]  err_q;
   logic        frame_open_q;
   logic [23:0] size_q;
   logic [31:0] pitch_q;
   logic [15:0] count_q;
   logic [63:0] line_base_q;
   logic [63:0] exp_addr_q;
   logic [23:0] line_byte_q;
   logic [15:0] line_idx_q;
   logic [9:0]  beats_left_q;

   logic        beat_ok;
   logic        push;
   logic        line_end;
   logic        last_line;
   logic [3:0]  tuser_d;
   logic [9:0]  len_beats_d;
   logic [9:0]  drop_beats_d;
   logic        fmt_bad;
   logic        align_bad;
   logic [63:0] line_base_d;
   logic        fifo_full;
   logic [FAW:0] fifo_free;
   logic [67:0] fifo_out;
   logic        unused_hdr;

   assign unused_hdr = ^{tlp_ldwbe_fdwbe, tlp_attr, tlp_transaction_id,
                         tlp_byte_count, tlp_lower_address};

   // beat acceptance, tuser derivation from counters, header decode
   always_comb begin
      beat_ok      = ((state_q == ST_DATA) || (state_q == ST_DROP)) &&
                     !tlp_src_rdy_n && !tlp_dst_rdy_n;
      push         = beat_ok && (state_q == ST_DATA);
      line_end     = ((line_byte_q + 24'd8) == size_q);
      last_line    = (line_idx_q == (count_q - 16'd1));
      tuser_d          = '0;
      tuser_d[TU_SOF]  = (line_byte_q == '0) && (line_idx_q == '0);
      tuser_d[TU_SOL]  = (line_byte_q == '0);
      tuser_d[TU_EOL]  = line_end;
      tuser_d[TU_EOF]  = line_end && last_line;
      len_beats_d  = (tlp_length_in_dw == '0) ? 10'd512 : {1'b0, tlp_length_in_dw[9:1]};
      drop_beats_d = len_beats_d + {9'd0, tlp_length_in_dw[0]};
      fmt_bad      = !fmt_supported(tlp_fmt_type);
      align_bad    = tlp_length_in_dw[0] || (tlp_address[2:0] != 3'd0);
      line_base_d  = line_base_q + {32'd0, pitch_q};
   end

   // transfer FSM with header latch, frame counters and registered outputs
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         dst_rdy_n_q  <= 1'b1;
         frame_done_q <= 1'b0;
         err_q        <= '0;
         frame_open_q <= 1'b0;
         size_q       <= '0;
         pitch_q      <= '0;
         count_q      <= '0;
         line_base_q  <= '0;
         exp_addr_q   <= '0;
         line_byte_q  <= '0;
         line_idx_q   <= '0;
         beats_left_q <= '0;
      end else begin
         grant_q      <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (tlp_req_to_send && (fifo_free >= (FAW+1)'(HEADROOM))) begin
                  state_q <= ST_GRANT;
                  grant_q <= 1'b1;
                  if (!frame_open_q) begin
                     frame_open_q <= 1'b1;
                     size_q       <= cfg_line_size;
                     pitch_q      <= cfg_line_pitch;
                     count_q      <= cfg_line_count;
                     line_base_q  <= cfg_fstart;
                     exp_addr_q   <= cfg_fstart;
                     line_byte_q  <= '0;
                     line_idx_q   <= '0;
                  end
               end
            end
            ST_GRANT: begin
               dst_rdy_n_q <= 1'b0;
               if (fmt_bad || align_bad) begin
                  if (fmt_bad)   err_q[ERR_FMT]   <= 1'b1;
                  if (align_bad) err_q[ERR_ALIGN] <= 1'b1;
                  beats_left_q <= drop_beats_d;
                  state_q      <= ST_DROP;
               end else begin
                  if (tlp_address != exp_addr_q) err_q[ERR_ADDR] <= 1'b1;
                  beats_left_q <= len_beats_d;
                  state_q      <= ST_DATA;
               end
            end
            ST_DATA, ST_DROP: begin
               if (beat_ok) begin
                  beats_left_q <= beats_left_q - 10'd1;
                  if (beats_left_q == 10'd1) begin
                     state_q     <= ST_IDLE;
                     dst_rdy_n_q <= 1'b1;
                  end
                  if (state_q == ST_DATA) begin
                     if (line_end) begin
                        line_byte_q <= '0;
                        line_idx_q  <= line_idx_q + 16'd1;
                        line_base_q <= line_base_d;
                        exp_addr_q  <= line_base_d;
                        if (last_line) begin
                           frame_done_q <= 1'b1;
                           frame_open_q <= 1'b0;
                        end
                     end else begin
                        line_byte_q <= line_byte_q + 24'd8;
                        exp_addr_q  <= exp_addr_q + 64'd8;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   tlp2axis_fifo #(
      .WIDTH (68),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (axi_clk),
      .rst_i       (axi_reset),
      .push_i      (push),
      .push_data_i ({tuser_d, tlp_data}),
      .pop_i       (m_axis_tready),
      .pop_data_o  (fifo_out),
      .valid_o     (m_axis_tvalid),
      .full_o      (fifo_full),
      .free_o      (fifo_free)
   );

   assign tlp_grant     = grant_q;
   assign tlp_dst_rdy_n = dst_rdy_n_q | fifo_full;
   assign frame_done    = frame_done_q;
   assign err_flags     = err_q;
   assign m_axis_tdata  = fifo_out[63:0];
   assign m_axis_tuser  = fifo_out[67:64];
   assign m_axis_tlast  = fifo_out[64 + TU_EOL];

endmodule
